gray_stream_src: RTL

//  Synthetic 12-bit grayscale frame source that generates the iDVAL/iGRAY pixel cadence consumed by image_proc.

---
 rtl/img_pkg.sv | 9 +
 rtl/pattern_lut.sv | 31 +++
 rtl/gray_stream_src.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared image-path types: 12-bit gray pixel, gray extremes and test-pattern selector.
package img_pkg;
  typedef logic [11:0] gray12_t;

  localparam gray12_t GRAY_MIN = 12'd0;
  localparam gray12_t GRAY_MAX = 12'd4095;

  typedef enum logic [1:0] {PAT_STEP, PAT_RAMP, PAT_CHECK, PAT_SOLID} pat_mode_e;
endpackage

// File: rtl/pattern_lut.sv
// Combinational test-pattern generator: (mode, x, y, level) -> gray pixel.
module pattern_lut
  import img_pkg::*;
#(
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int EDGE_X     = 320,
  parameter int CHECK_LOG2 = 5
) (
  input  pat_mode_e         mode,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  gray12_t           level,
  output gray12_t           gray
);
  logic cx, cy;

  // Shift-then-take-LSB keeps the square size legal even if it exceeds the coordinate width.
  assign cx = 1'(x >> CHECK_LOG2);
  assign cy = 1'(y >> CHECK_LOG2);

  always_comb begin
    gray = GRAY_MIN;
    case (mode)
      PAT_STEP:  gray = (32'(x) < EDGE_X) ? GRAY_MIN : GRAY_MAX;
      PAT_RAMP:  gray = 12'({x, 2'b00});
      PAT_CHECK: gray = (cx ^ cy) ? GRAY_MAX : GRAY_MIN;
      default:   gray = level;
    endcase
  end
endmodule

// File: rtl/gray_stream_src.sv
// Synthetic grayscale frame source: raster cadence FSM with H/V blanking and registered pixel outputs.
module gray_stream_src
  import img_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int H_BLANK    = 20,
  parameter int V_BLANK    = 100,
  parameter int EDGE_X     = 320,
  parameter int CHECK_LOG2 = 5,
  localparam int XW        = $clog2(IMG_W),
  localparam int YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iEN,
  input  logic [1:0]    iMODE,
  input  logic [11:0]   iLEVEL,
  output logic          oDVAL,
  output logic [11:0]   oGRAY,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oSOF,
  output logic          oEOL,
  output logic          oFRAME_DONE,
  output logic          oBUSY
);
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HBLANK = 2'd2;
  localparam logic [1:0] S_VBLANK = 2'd3;

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

  logic [1:0]    st, st_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [BW-1:0] cnt, cnt_n;
  pat_mode_e     mode_q, mode_n;
  gray12_t       level_q, level_n;
  gray12_t       gray_n;
  logic          dval_n, fd_n;

  always_comb begin
    st_n    = st;
    x_n     = x;
    y_n     = y;
    cnt_n   = cnt;
    mode_n  = mode_q;
    level_n = level_q;
    case (st)
      S_IDLE: begin
        if (iEN) begin
          st_n    = S_ACTIVE;
          x_n     = '0;
          y_n     = '0;
          mode_n  = pat_mode_e'(iMODE);
          level_n = iLEVEL;
        end
      end
      S_ACTIVE: begin
        if (x == X_LAST) begin
          cnt_n = '0;
          st_n  = (y == Y_LAST) ? S_VBLANK : S_HBLANK;
        end else begin
          x_n = x + 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          st_n = S_ACTIVE;
          x_n  = '0;
          y_n  = y + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        // Back-to-back frames restart straight from the last vblank cycle, no extra gap.
        if (cnt == VB_LAST) begin
          if (iEN) begin
            st_n    = S_ACTIVE;
            x_n     = '0;
            y_n     = '0;
            mode_n  = pat_mode_e'(iMODE);
            level_n = iLEVEL;
          end else begin
            st_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  // Outputs are computed from next-state so the first pixel lands on the edge that samples iEN.
  assign dval_n = (st_n == S_ACTIVE);
  assign fd_n   = (st_n == S_VBLANK) && (cnt_n == VB_LAST);

  pattern_lut #(
    .XW(XW), .YW(YW), .EDGE_X(EDGE_X), .CHECK_LOG2(CHECK_LOG2)
  ) u_lut (
    .mode(mode_n), .x(x_n), .y(y_n), .level(level_n), .gray(gray_n)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      st          <= S_IDLE;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      mode_q      <= PAT_STEP;
      level_q     <= '0;
      oDVAL       <= 1'b0;
      oGRAY       <= '0;
      oX          <= '0;
      oY          <= '0;
      oSOF        <= 1'b0;
      oEOL        <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      st          <= st_n;
      x           <= x_n;
      y           <= y_n;
      cnt         <= cnt_n;
      mode_q      <= mode_n;
      level_q     <= level_n;
      oDVAL       <= dval_n;
      oGRAY       <= dval_n ? gray_n : '0;
      oX          <= dval_n ? x_n : '0;
      oY          <= dval_n ? y_n : '0;
      oSOF        <= dval_n && (x_n == '0) && (y_n == '0);
      oEOL        <= dval_n && (x_n == X_LAST);
      oFRAME_DONE <= fd_n;
      oBUSY       <= (st_n != S_IDLE);
    end
  end
endmodule
